// File: rtl/irq_ctrl6502.sv
// irq_ctrl6502: multi-channel interrupt controller for the 6502 core.
// Merges up to 8 sources into one registered `intr` line. It supports
// priority, per-channel masking, edge/level modes and a per-channel vector.
// Ports:
//   clock, reset_n       system clock, synchronous active-low reset
//   hold                 clock enable; 0 freezes all state and ignores writes
//   address, din, we     core bus; register window at BASE..BASE+3
//   dout                 combinational read data (0 outside the window)
//   irq_in[CHANNELS]     interrupt sources, synchronous to clock
//   intr, vector         registered request line and selected vector address
module irq_ctrl6502 #(
  parameter int unsigned CHANNELS    = 8,
  parameter logic [15:0] BASE        = 16'hDF00,
  parameter logic [15:0] VECTOR_BASE = 16'hFFE0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                hold,
  input  logic [15:0]         address,
  input  logic [7:0]          din,
  input  logic                we,
  output logic [7:0]          dout,
  input  logic [CHANNELS-1:0] irq_in,
  output logic                intr,
  output logic [15:0]         vector
);

  localparam int unsigned DW      = 8;
  localparam logic [DW-1:0] CH_MASK = DW'((16'd1 << CHANNELS) - 16'd1);

  localparam logic [1:0] OFF_PEND = 2'd0;
  localparam logic [1:0] OFF_MASK = 2'd1;
  localparam logic [1:0] OFF_CTRL = 2'd2;
  localparam logic [1:0] OFF_MODE = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } state_t;

  state_t        state;
  logic [2:0]    chan;
  logic [DW-1:0] pending;
  logic [DW-1:0] mask;
  logic [DW-1:0] mode;
  logic [DW-1:0] irq_prev;

  logic          hit;
  logic          wr_pend;
  logic          wr_mask;
  logic          wr_ctrl;
  logic          wr_mode;
  logic          ack;
  logic          eoi;
  logic [DW-1:0] irq_ext;
  logic [DW-1:0] mask_next;
  logic [DW-1:0] mode_next;
  logic [DW-1:0] clr;
  logic [DW-1:0] pending_next;
  logic [DW-1:0] req;
  logic [2:0]    lo_idx;
  logic          valid;

  // Bus decode and write strobes
  always_comb begin
    hit     = (address[15:2] == BASE[15:2]);
    wr_pend = hit && we && hold && (address[1:0] == OFF_PEND);
    wr_mask = hit && we && hold && (address[1:0] == OFF_MASK);
    wr_ctrl = hit && we && hold && (address[1:0] == OFF_CTRL);
    wr_mode = hit && we && hold && (address[1:0] == OFF_MODE);
    ack     = wr_ctrl && din[0] && (state == REQ);
    eoi     = wr_ctrl && din[1] && (state == SERVICE);
  end

  // Next pending: level channels mirror the input (using the new mode so an
  // edge->level switch drops the latched bit); edge channels latch rising
  // edges, and a new edge beats any clear in the same cycle.
  always_comb begin
    irq_ext      = DW'(irq_in);
    mask_next    = wr_mask ? (din & CH_MASK) : mask;
    mode_next    = wr_mode ? (din & CH_MASK) : mode;
    clr          = (wr_pend ? din : '0) | (ack ? (DW'(1) << chan) : '0);
    pending_next = CH_MASK & ((mode_next & irq_ext) |
                              (~mode_next & ((pending & ~clr) | (irq_ext & ~irq_prev))));
  end

  // Lowest-index active request wins
  always_comb begin
    req    = pending & mask;
    lo_idx = '0;
    for (int i = int'(DW) - 1; i >= 0; i--) begin
      if (req[i]) lo_idx = 3'(i);
    end
  end

  assign valid = (state != IDLE);

  // Register read mux
  always_comb begin
    dout = '0;
    if (hit) begin
      case (address[1:0])
        OFF_PEND: dout = pending;
        OFF_MASK: dout = mask;
        OFF_CTRL: dout = {valid, 2'(state), 2'b00, chan};
        OFF_MODE: dout = mode;
        default:  dout = '0;
      endcase
    end
  end

  // Registers and request/acknowledge state machine
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      chan     <= '0;
      pending  <= '0;
      mask     <= '0;
      mode     <= '0;
      irq_prev <= '0;
      intr     <= 1'b0;
      vector   <= VECTOR_BASE;
    end else if (hold) begin
      pending  <= pending_next;
      mask     <= mask_next;
      mode     <= mode_next;
      irq_prev <= irq_ext & CH_MASK;
      case (state)
        IDLE: begin
          if (req != '0) begin
            chan   <= lo_idx;
            vector <= VECTOR_BASE + 16'({lo_idx, 1'b0});
            intr   <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (ack) begin
            intr  <= 1'b0;
            state <= SERVICE;
          end else if (!req[chan]) begin
            intr  <= 1'b0;
            state <= IDLE;
          end
        end
        SERVICE: begin
          intr <= 1'b0;
          if (eoi) state <= IDLE;
        end
        default: begin
          intr  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/irq_ctrl6502.md
Name: irq_ctrl6502

Overview:
Parametrised multi-channel interrupt controller for the 6502 core. It merges up to 8 interrupt sources into the single `intr` line the core samples, using priority, per-channel masking and edge/level modes. It also supplies a per-channel vector address. Software controls it through four memory-mapped registers on the core bus (address/in/out/we).

Parameters:
CHANNELS, 8, number of interrupt sources (1..8); unused bits read 0 and ignore writes
BASE, 16'hDF00, register window base; must be 4-byte aligned; occupies BASE..BASE+3
VECTOR_BASE, 16'hFFE0, base of the vector table; channel n vector = VECTOR_BASE + 2*n

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous, active-low reset
hold  in  1  clock enable; when 0, all state is frozen and writes are ignored
address  in  16  core address bus
din  in  8  core write data (core `out`)
we  in  1  core write strobe
dout  out  8  read data, combinational from address; 8'h00 when address is outside the window
irq_in  in  CHANNELS  interrupt source lines, synchronous to clock
intr  out  1  registered interrupt request to the core
vector  out  16  registered vector address of the selected channel

Behaviour:
- Reset (reset_n=0 at posedge, regardless of hold): pending=0, mask=0, mode=0 (all edge), irq_prev=0, state=IDLE, chan=0, intr=0, vector=VECTOR_BASE.
- Window hit: address[15:2]==BASE[15:2]. A write occurs when hit && we && hold at posedge. Reads have no side effects.
- Registers:
  - offset 0 PEND: read returns pending; write of 1 clears that edge bit.
  - offset 1 MASK: read/write; 1 = channel enabled.
  - offset 2 CTRL: read returns {valid, state[1:0], 2'b0, chan[2:0]}. Write din[0]=1 is ACK; write din[1]=1 is EOI.
  - offset 3 MODE: read/write; 1 = level-sensitive channel.
- Edge channel:
  - irq_prev is updated every enabled cycle.
  - pending sets on irq_in & ~irq_prev.
  - A set and a write-1-clear in the same cycle: set wins.
- Level channel:
  - pending mirrors irq_in with one cycle of register delay.
  - Write-1-clear has no effect.
  - Changing MODE from edge to level discards the latched edge bit.
- req = pending & mask. Priority: lowest index wins.
- State machine:
  - IDLE: if req!=0, latch chan=lowest set index, vector<=VECTOR_BASE+{chan,1'b0}, intr<=1, go to REQ.
  - REQ: on ACK write, go to SERVICE, intr<=0, and clear pending[chan] if chan is edge mode. If req[chan] drops before ACK (masked, or cleared by software), intr<=0 and go to IDLE. chan stays latched, and valid reads 0 in IDLE.
  - SERVICE: intr=0 and no nesting. On EOI write, go to IDLE. A new request can raise intr no earlier than one cycle after EOI.
- valid = (state!=IDLE).
- ACK outside REQ and EOI outside SERVICE are ignored. If ACK and EOI are written together in REQ, only ACK is taken.
- Latency: edge at irq_in sampled at posedge k → pending at k → intr high after posedge k+1 (2 cycles).
- Because intr returns to 0 after ACK, the core's 0→1 edge detect re-arms for the next request.
- Level channel still high after EOI: it re-requests.
- reset_n low mid-REQ/SERVICE: immediate return to reset values; intr drops the next cycle.
- hold=0: intr, vector and dout inputs are held; edges that occur while hold=0 are detected on resume against the frozen irq_prev.

Test Plan:
1. Reset; MASK=8'h01; pulse irq_in[0] for 1 cycle → pending=01, intr=1 two cycles after the edge, vector=16'hFFE0; read CTRL=8'hA0 (valid=1, REQ=2'b01).
2. Write CTRL=01 (ACK) → intr=0, PEND=00, CTRL reads 8'hC0; write CTRL=02 (EOI) → CTRL=00, intr stays 0.
3. MASK=FF; raise irq_in[5] and irq_in[2] in the same cycle → chan=2, vector=16'hFFE4; after ACK and EOI → chan=5, vector=16'hFFEA.
4. MODE=01, hold irq_in[0]=1 → ACK and EOI → intr reasserts one cycle later; writing PEND=01 has no effect; dropping irq_in[0] clears pending.
5. Request on channel 3 in REQ, then write MASK=00 before ACK → intr=0, state IDLE; a later ACK write is ignored.
6. Assert reset_n=0 during SERVICE with pending=FF → all registers 0, intr=0, vector=FFE0; hold=0 during an edge → no state change until hold=1.
